ram_arbiter: RTL

Two-port arbiter that shares the single-port 256 x 16 data RAM (`ram`) between the instruction-fetch unit (port 0) and the load/store unit (port 1). It accepts independent request/grant handshakes, selects one winner per access and drives the RAM's `we`/`addr`/`data_in` from registers. For reads it returns `data_out` to the winning requester with a one-cycle valid strobe. It sits between the CPU core and `ram`, and is the only driver of the RAM control inputs.

---
 rtl/ram_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing a single-port data RAM between fetch and LSU.
// Define RAM_ARB_FIXED_PRIO_EN for fixed port-0 priority (default: round-robin).
module ram_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RWAIT
  } state_t;

  state_t state;
  logic   own;
  logic   pick1;

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign pick1 = req1 & ~req0;
`else
  logic last;
  assign pick1 = req1 & (~req0 | ~last);
`endif

  assign busy = (state != IDLE);

  // Arbitration, RAM command registers and read-return sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      own      <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last     <= 1'b1;
`endif
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      ram_we  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req0 | req1) begin
            own      <= pick1;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last     <= pick1;
`endif
            ram_addr <= pick1 ? addr1 : addr0;
            ram_we   <= pick1 ? we1 : we0;
            ram_din  <= pick1 ? wdata1 : wdata0;
            gnt0     <= ~pick1;
            gnt1     <= pick1;
            state    <= GRANT;
          end
        end
        GRANT: begin
          state <= ram_we ? IDLE : RWAIT;
        end
        RWAIT: begin
          if (own) begin
            rdata1  <= ram_dout;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= ram_dout;
            rvalid0 <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
